// File: rtl/demux4_dispatcher.sv
// rtl/demux4_dispatcher.sv - one-to-four word dispatcher with addressed and round-robin steering
module demux4_dispatcher #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_sel,
  input  logic              mode,
  input  logic [3:0]        ch_en,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        rr_ptr,
  output logic              drop_err,
  output logic [15:0]       dispatch_cnt,
  output logic [7:0]        drop_cnt
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t              state_q, state_d;
  logic [1:0]          tgt_q, tgt_d;
  logic [1:0]          rr_q, rr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                drop_err_q, drop_err_d;
  logic [15:0]         disp_q, disp_d;
  logic [7:0]          drop_q, drop_d;

  logic                can_take;
  logic                deliver;
  logic                accept;
  logic                tgt_ok;
  logic [1:0]          new_tgt;

  // First enabled channel found scanning upward from start, wrapping mod 4.
  function automatic logic [1:0] rr_pick(input logic [1:0] start, input logic [3:0] en);
    logic [1:0] pick;
    logic [1:0] idx;
    pick = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (en[idx]) pick = idx;
    end
    return pick;
  endfunction

  // Target choice, handshakes and next-state for the IDLE/HOLD controller.
  always_comb begin
    can_take   = ~mode | (|ch_en);
    new_tgt    = mode ? rr_pick(rr_q, ch_en) : in_sel;
    tgt_ok     = mode ? (|ch_en) : ch_en[in_sel];
    deliver    = (state_q == HOLD) && out_ready[tgt_q];

    if (rst) begin
      in_ready = 1'b0;
    end else if (state_q == IDLE) begin
      in_ready = can_take;
    end else begin
      in_ready = out_ready[tgt_q] & can_take;
    end
    accept = in_valid & in_ready;

    state_d    = state_q;
    tgt_d      = tgt_q;
    data_d     = data_q;
    rr_d       = rr_q;
    drop_err_d = 1'b0;
    disp_d     = disp_q;
    drop_d     = drop_q;

    if (deliver) begin
      disp_d  = disp_q + 16'd1;
      state_d = IDLE;
    end

    if (accept) begin
      if (tgt_ok) begin
        state_d = HOLD;
        tgt_d   = new_tgt;
        data_d  = in_data;
        if (mode) rr_d = new_tgt + 2'd1;
      end else begin
        drop_err_d = 1'b1;
        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end
    end
  end

  // State register; reset discards any held word without counting it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tgt_q      <= 2'd0;
      data_q     <= '0;
      rr_q       <= 2'd0;
      drop_err_q <= 1'b0;
      disp_q     <= 16'd0;
      drop_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      data_q     <= data_d;
      rr_q       <= rr_d;
      drop_err_q <= drop_err_d;
      disp_q     <= disp_d;
      drop_q     <= drop_d;
    end
  end

  assign out_valid    = (state_q == HOLD) ? (4'b0001 << tgt_q) : 4'b0000;
  assign out_data     = data_q;
  assign rr_ptr       = rr_q;
  assign drop_err     = drop_err_q;
  assign dispatch_cnt = disp_q;
  assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_demux4_dispatcher.sv
// tb/tb_demux4_dispatcher.sv - self-checking bench for demux4_dispatcher
module tb_demux4_dispatcher;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        mode;
  logic [3:0]  ch_en;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [7:0]  out_data;
  logic [1:0]  rr_ptr;
  logic        drop_err;
  logic [15:0] dispatch_cnt;
  logic [7:0]  drop_cnt;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_on  = 0;

  demux4_dispatcher #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .mode(mode), .ch_en(ch_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .rr_ptr(rr_ptr), .drop_err(drop_err), .dispatch_cnt(dispatch_cnt),
    .drop_cnt(drop_cnt)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: at most one pending word, described by the delivery rules.
  bit       m_hold;
  int       m_tgt;
  int       m_data;
  int       m_rr;
  int       m_disp;
  int       m_drop;
  bit       m_derr;

  function automatic bit m_in_ready();
    bit base;
    if (rst) return 0;
    base = (mode == 1'b0) || (ch_en != 4'b0000);
    if (!m_hold) return base;
    return out_ready[m_tgt] && base;
  endfunction

  always @(posedge clk) begin
    bit acc, ok;
    int t;
    if (rst) begin
      m_hold = 0; m_tgt = 0; m_data = 0; m_rr = 0; m_disp = 0; m_drop = 0; m_derr = 0;
    end else begin
      acc = in_valid && m_in_ready();
      m_derr = 0;
      if (m_hold && out_ready[m_tgt]) begin
        m_disp = (m_disp + 1) % 65536;
        m_hold = 0;
      end
      if (acc) begin
        t = 0;
        ok = 0;
        if (mode) begin
          for (int k = 0; k < 4; k++) begin
            if (!ok && ch_en[(m_rr + k) % 4]) begin
              t = (m_rr + k) % 4;
              ok = 1;
            end
          end
        end else begin
          t = int'(in_sel);
          ok = ch_en[t];
        end
        if (ok) begin
          m_hold = 1;
          m_tgt  = t;
          m_data = int'(in_data);
          if (mode) m_rr = (t + 1) % 4;
        end else begin
          m_derr = 1;
          if (m_drop < 255) m_drop++;
        end
      end
    end
  end

  // Every cycle after the first reset, outputs must agree with the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("in_ready", 32'(in_ready), 32'(m_in_ready()));
      chk("out_valid", 32'(out_valid), m_hold ? (32'd1 << m_tgt) : 32'd0);
      if (m_hold) chk("out_data", 32'(out_data), 32'(m_data));
      chk("rr_ptr", 32'(rr_ptr), 32'(m_rr));
      chk("drop_err", 32'(drop_err), 32'(m_derr));
      chk("dispatch_cnt", 32'(dispatch_cnt), 32'(m_disp));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    step();
    rst = 0;
    chk_on = 1;
  endtask

  int exp_t[4]  = '{1, 3, 1, 3};
  int exp_rr[4] = '{2, 0, 2, 0};

  initial begin
    rst = 1; in_valid = 0; in_data = 0; in_sel = 0; mode = 0; ch_en = 4'hF; out_ready = 4'h0;
    step();
    do_reset();
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_out_data", 32'(out_data), 32'h0);
    chk("reset_counts", {dispatch_cnt, drop_cnt, 6'd0, rr_ptr}, 32'h0);

    // Addressed, all channels enabled, one word per cycle.
    mode = 0; ch_en = 4'hF; out_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_sel = 2'(i); in_data = 8'hA0 + 8'(i);
      step();
      chk("addr_valid", 32'(out_valid), 32'd1 << i);
      chk("addr_data", 32'(out_data), 32'hA0 + 32'(i));
    end
    in_valid = 0;
    step();
    chk("addr_dispatch", 32'(dispatch_cnt), 32'd4);

    // Round-robin over channels 1 and 3.
    do_reset();
    mode = 1; ch_en = 4'b1010; out_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_data = 8'h10 + 8'(i);
      step();
      chk("rr_tgt", 32'(out_valid), 32'd1 << exp_t[i]);
      chk("rr_ptr_seq", 32'(rr_ptr), 32'(exp_rr[i]));
    end
    in_valid = 0;
    step();

    // Backpressure on channel 2, other readies ignored.
    do_reset();
    mode = 0; ch_en = 4'hF; out_ready = 4'h0; in_sel = 2; in_data = 8'h3C; in_valid = 1;
    step();
    in_valid = 0; in_data = 8'h77;
    for (int i = 0; i < 7; i++) begin
      out_ready = (i < 5) ? 4'b0000 : 4'b1011;
      #1;
      chk("bp_valid", 32'(out_valid), 32'h4);
      chk("bp_data", 32'(out_data), 32'h3C);
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      step();
    end
    out_ready = 4'b0100;
    step();
    chk("bp_dispatch", 32'(dispatch_cnt), 32'd1);
    chk("bp_idle", 32'(out_valid), 32'h0);

    // Addressed word to a disabled channel is dropped, count saturates.
    do_reset();
    mode = 0; ch_en = 4'b1110; in_sel = 0; in_data = 8'h55; in_valid = 1;
    step();
    in_valid = 0;
    chk("drop_pulse", 32'(drop_err), 32'h1);
    chk("drop_cnt1", 32'(drop_cnt), 32'd1);
    chk("drop_noval", 32'(out_valid), 32'h0);
    chk("drop_nodisp", 32'(dispatch_cnt), 32'd0);
    step();
    chk("drop_pulse_end", 32'(drop_err), 32'h0);
    in_valid = 1;
    repeat (300) step();
    in_valid = 0;
    step();
    chk("drop_sat", 32'(drop_cnt), 32'd255);

    // Round-robin with nothing enabled stalls the producer.
    do_reset();
    mode = 1; ch_en = 4'h0; out_ready = 4'h0; in_valid = 1; in_data = 8'h99;
    repeat (4) begin
      step();
      chk("stall_in_ready", 32'(in_ready), 32'h0);
    end
    ch_en = 4'b0100;
    step();
    in_valid = 0;
    chk("stall_tgt", 32'(out_valid), 32'h4);
    chk("stall_data", 32'(out_data), 32'h99);
    out_ready = 4'b0100;
    step();
    chk("stall_dispatch", 32'(dispatch_cnt), 32'd1);

    // Reset while a word for channel 3 is held.
    mode = 0; ch_en = 4'hF; out_ready = 4'h0; in_sel = 3; in_data = 8'hEE; in_valid = 1;
    step();
    in_valid = 0;
    chk("mid_hold", 32'(out_valid), 32'h8);
    do_reset();
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_rr", 32'(rr_ptr), 32'h0);
    chk("mid_rst_cnt", {dispatch_cnt, drop_cnt, 8'd0}, 32'h0);
    out_ready = 4'hF;
    step(); step();
    chk("mid_no_deliver", 32'(dispatch_cnt), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      in_sel    = 2'($urandom);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      if ($urandom_range(0, 7) == 0) ch_en = 4'($urandom);
      out_ready = 4'($urandom);
      step();
    end
    rst = 0; in_valid = 0;
    step();

    chk_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
